// File: rtl/display_scan_mux.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Scans on rising edges of NFrec and snapshots the digit values once per frame.
module display_scan_mux #(
  parameter int LZ_BLANK    = 1,
  parameter int DEAD_CYCLES = 2
) (
  input  logic        cLocK,
  input  logic        Reset,
  input  logic        NFrec,
  input  logic        enable,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        frame_done
);

  localparam logic [2:0] DEAD = 3'(DEAD_CYCLES);

  logic        nfrec_q;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] shadow_dig, shadow_dig_nxt;
  logic [3:0]  shadow_dp, shadow_dp_nxt;
  logic [2:0]  blank_cnt, blank_cnt_nxt;
  logic        step, wrap, lit;
  logic [3:0]  nib;
  logic [3:0]  an_nxt;
  logic [6:0]  seg_nxt;
  logic        dp_nxt;

  function automatic logic [6:0] decode_bcd(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // A digit is a leading zero when it and every digit to its left are zero.
  function automatic logic is_leading_zero(input logic [15:0] dig, input logic [1:0] i);
    case (i)
      2'd3:    return dig[15:12] == 4'd0;
      2'd2:    return dig[15:8] == 8'd0;
      2'd1:    return dig[15:4] == 12'd0;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    step           = NFrec & ~nfrec_q & enable;
    wrap           = step & (idx == 2'd3);
    idx_nxt        = step ? idx + 2'd1 : idx;
    shadow_dig_nxt = wrap ? digits_in : shadow_dig;
    shadow_dp_nxt  = wrap ? dp_in : shadow_dp;

    if (step)
      blank_cnt_nxt = DEAD;
    else if (enable && blank_cnt != 3'd0)
      blank_cnt_nxt = blank_cnt - 3'd1;
    else
      blank_cnt_nxt = blank_cnt;

    // Outputs are registered from the post-edge state, so decode the next values.
    lit    = enable && (blank_cnt_nxt == 3'd0);
    nib    = 4'(shadow_dig_nxt >> {idx_nxt, 2'b00});
    an_nxt = 4'b1111;
    seg_nxt = 7'b1111111;
    dp_nxt = 1'b1;
    if (lit) begin
      an_nxt = ~(4'b0001 << idx_nxt);
      dp_nxt = ~shadow_dp_nxt[idx_nxt];
      if (!(LZ_BLANK != 0 && is_leading_zero(shadow_dig_nxt, idx_nxt)))
        seg_nxt = decode_bcd(nib);
    end
  end

  always_ff @(posedge cLocK) begin
    if (Reset) begin
      nfrec_q    <= 1'b1;
      idx        <= 2'd0;
      shadow_dig <= 16'd0;
      shadow_dp  <= 4'd0;
      blank_cnt  <= 3'd0;
      AN         <= 4'b1111;
      SEG        <= 7'b1111111;
      DP         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      nfrec_q    <= NFrec;
      idx        <= idx_nxt;
      shadow_dig <= shadow_dig_nxt;
      shadow_dp  <= shadow_dp_nxt;
      blank_cnt  <= blank_cnt_nxt;
      AN         <= an_nxt;
      SEG        <= seg_nxt;
      DP         <= dp_nxt;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with LZ_BLANK=1 and DEAD_CYCLES=2.
module tb_display_scan_mux;

  logic        cLocK = 1'b0;
  logic        Reset;
  logic        NFrec;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  display_scan_mux #(.LZ_BLANK(1), .DEAD_CYCLES(2)) dut (
    .cLocK(cLocK), .Reset(Reset), .NFrec(NFrec), .enable(enable),
    .digits_in(digits_in), .dp_in(dp_in),
    .AN(AN), .SEG(SEG), .DP(DP), .frame_done(frame_done)
  );

  always #5 cLocK = ~cLocK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Raise NFrec; returns at the negedge just after the step edge.
  task automatic nfrec_rise();
    @(negedge cLocK);
    NFrec = 1'b1;
    @(negedge cLocK);
  endtask

  task automatic nfrec_fall();
    NFrec = 1'b0;
    repeat (5) @(negedge cLocK);
  endtask

  task automatic test_reset();
    Reset = 1'b1; enable = 1'b1; NFrec = 1'b1;
    digits_in = 16'h1234; dp_in = 4'b0000;
    repeat (3) @(negedge cLocK);
    checks++; if (AN !== 4'b1111) begin errors++; $display("FAIL reset_an got %b want 1111", AN); end
    checks++; if (SEG !== 7'b1111111) begin errors++; $display("FAIL reset_seg got %b want 1111111", SEG); end
    checks++; if (DP !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", DP); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
    Reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge cLocK);
      checks++; if (AN !== 4'b1110) begin errors++; $display("FAIL first_digit_an c%0d got %b want 1110", k, AN); end
      checks++; if (SEG !== 7'b1000000) begin errors++; $display("FAIL first_digit_seg c%0d got %b want 1000000", k, SEG); end
    end
    nfrec_fall();
  endtask

  task automatic test_scan_order();
    logic [3:0] an_t [8];
    logic [6:0] seg_t [8];
    logic       fd_t [8];
    an_t  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    seg_t = '{7'b1111111, 7'b1111111, 7'b1111111, 7'b0011001,
              7'b0110000, 7'b0100100, 7'b1111001, 7'b0011001};
    fd_t  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 8; k++) begin
      nfrec_rise();
      checks++; if (AN !== 4'b1111) begin errors++; $display("FAIL scan_dead1 s%0d AN got %b want 1111", k, AN); end
      checks++; if (frame_done !== fd_t[k]) begin errors++; $display("FAIL scan_fd s%0d got %b want %b", k, frame_done, fd_t[k]); end
      @(negedge cLocK);
      checks++; if (AN !== 4'b1111) begin errors++; $display("FAIL scan_dead2 s%0d AN got %b want 1111", k, AN); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL scan_fd_width s%0d got %b want 0", k, frame_done); end
      @(negedge cLocK);
      checks++; if (AN !== an_t[k]) begin errors++; $display("FAIL scan_an s%0d got %b want %b", k, AN, an_t[k]); end
      checks++; if (SEG !== seg_t[k]) begin errors++; $display("FAIL scan_seg s%0d got %b want %b", k, SEG, seg_t[k]); end
      checks++; if (DP !== 1'b1) begin errors++; $display("FAIL scan_dp s%0d got %b want 1", k, DP); end
      nfrec_fall();
    end
  endtask

  task automatic test_lz_dp_invalid();
    logic [3:0] an_t [9];
    logic [6:0] seg_t [9];
    logic       dp_t [9];
    logic       fd_t [9];
    an_t  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    seg_t = '{7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000, 7'b0010010,
              7'b1111111, 7'b1111111, 7'b1000000, 7'b0111111};
    dp_t  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    fd_t  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    digits_in = 16'h0050; dp_in = 4'b0100;
    for (int k = 0; k < 9; k++) begin
      if (k == 7) begin digits_in = 16'h00A0; dp_in = 4'b0000; end
      nfrec_rise();
      checks++; if (frame_done !== fd_t[k]) begin errors++; $display("FAIL lz_fd s%0d got %b want %b", k, frame_done, fd_t[k]); end
      repeat (2) @(negedge cLocK);
      checks++; if (AN !== an_t[k]) begin errors++; $display("FAIL lz_an s%0d got %b want %b", k, AN, an_t[k]); end
      checks++; if (SEG !== seg_t[k]) begin errors++; $display("FAIL lz_seg s%0d got %b want %b", k, SEG, seg_t[k]); end
      checks++; if (DP !== dp_t[k]) begin errors++; $display("FAIL lz_dp s%0d got %b want %b", k, DP, dp_t[k]); end
      nfrec_fall();
    end
  endtask

  task automatic test_snapshot();
    logic [3:0] an_t [8];
    logic [6:0] seg_t [8];
    logic       fd_t [8];
    an_t  = '{4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    seg_t = '{7'b1111111, 7'b1111111, 7'b1111001, 7'b1111001,
              7'b1111001, 7'b1111001, 7'b0100100, 7'b0100100};
    fd_t  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    digits_in = 16'h1111;
    for (int k = 0; k < 8; k++) begin
      if (k == 5) digits_in = 16'h2222;
      nfrec_rise();
      checks++; if (frame_done !== fd_t[k]) begin errors++; $display("FAIL snap_fd s%0d got %b want %b", k, frame_done, fd_t[k]); end
      repeat (2) @(negedge cLocK);
      checks++; if (AN !== an_t[k]) begin errors++; $display("FAIL snap_an s%0d got %b want %b", k, AN, an_t[k]); end
      checks++; if (SEG !== seg_t[k]) begin errors++; $display("FAIL snap_seg s%0d got %b want %b", k, SEG, seg_t[k]); end
      nfrec_fall();
    end
  endtask

  task automatic test_enable_freeze();
    @(negedge cLocK);
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge cLocK);
      checks++; if (AN !== 4'b1111) begin errors++; $display("FAIL freeze_an c%0d got %b want 1111", i, AN); end
      NFrec = ((i % 10) >= 5);
    end
    checks++; if (SEG !== 7'b1111111) begin errors++; $display("FAIL freeze_seg got %b want 1111111", SEG); end
    NFrec = 1'b0; enable = 1'b1;
    @(negedge cLocK);
    checks++; if (AN !== 4'b1101) begin errors++; $display("FAIL resume_idx_an got %b want 1101", AN); end
    checks++; if (SEG !== 7'b0100100) begin errors++; $display("FAIL resume_seg got %b want 0100100", SEG); end
    repeat (3) @(negedge cLocK);
    nfrec_rise();
    repeat (2) @(negedge cLocK);
    checks++; if (AN !== 4'b1011) begin errors++; $display("FAIL resume_step_an got %b want 1011", AN); end
    nfrec_fall();
  endtask

  task automatic test_reset_mid_dead();
    logic [3:0] an_t [4];
    logic [6:0] seg_t [4];
    logic       fd_t [4];
    an_t  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    seg_t = '{7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100};
    fd_t  = '{1'b0, 1'b0, 1'b0, 1'b1};
    nfrec_rise();
    checks++; if (AN !== 4'b1111) begin errors++; $display("FAIL mid_dead_an got %b want 1111", AN); end
    Reset = 1'b1;
    @(negedge cLocK);
    checks++; if (AN !== 4'b1111) begin errors++; $display("FAIL mid_reset_an got %b want 1111", AN); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_reset_fd got %b want 0", frame_done); end
    checks++; if (SEG !== 7'b1111111) begin errors++; $display("FAIL mid_reset_seg got %b want 1111111", SEG); end
    Reset = 1'b0;
    @(negedge cLocK);
    checks++; if (AN !== 4'b1110) begin errors++; $display("FAIL restart_an got %b want 1110", AN); end
    checks++; if (SEG !== 7'b1000000) begin errors++; $display("FAIL restart_seg got %b want 1000000", SEG); end
    nfrec_fall();
    for (int k = 0; k < 4; k++) begin
      nfrec_rise();
      checks++; if (frame_done !== fd_t[k]) begin errors++; $display("FAIL restart_fd s%0d got %b want %b", k, frame_done, fd_t[k]); end
      repeat (2) @(negedge cLocK);
      checks++; if (AN !== an_t[k]) begin errors++; $display("FAIL restart_scan_an s%0d got %b want %b", k, AN, an_t[k]); end
      checks++; if (SEG !== seg_t[k]) begin errors++; $display("FAIL restart_scan_seg s%0d got %b want %b", k, SEG, seg_t[k]); end
      nfrec_fall();
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_lz_dp_invalid();
    test_snapshot();
    test_enable_freeze();
    test_reset_mid_dead();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Time-multiplexed driver for the board's 4-digit, common-anode 7-segment display. It sits directly downstream of the frequency divider and consumes that block's `NFrec` square wave as its scan pacing signal. Each rising edge of `NFrec` advances to the next digit. Per digit, the block decodes a BCD nibble to active-low segments. Digit values are snapshotted once per frame, so a frame never mixes old and new values.

## Interface
Parameters:
- `LZ_BLANK`, default 1: 1 = suppress leading zeros on digits 3..1; 0 = always show all digits.
- `DEAD_CYCLES`, default 2: number of `cLocK` cycles with all anodes off after each digit switch (anti-ghosting). Legal range 0..7.

Ports:
- `cLocK`, in, 1: system clock; all logic on its rising edge.
- `Reset`, in, 1: synchronous, active-high; overrides all other inputs.
- `NFrec`, in, 1: divided square wave from the frequency divider, same clock domain. Its rising edge is the scan step.
- `enable`, in, 1: 1 = scanning active; 0 = display dark and scan frozen.
- `digits_in`, in, 16: BCD digits; [15:12] is digit 3 (leftmost), [3:0] is digit 0 (rightmost).
- `dp_in`, in, 4: decimal point request per digit, active-high; bit i belongs to digit i.
- `AN`, out, 4: anode selects, active-low; bit i drives digit i.
- `SEG`, out, 7: segments, active-low; bit0 = a … bit6 = g.
- `DP`, out, 1: decimal point, active-low.
- `frame_done`, out, 1: one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- **Edge detect:** `nfrec_q` holds `NFrec` delayed one cycle. `step = NFrec & ~nfrec_q & enable`.
- **Digit index:** `idx` is a 2-bit counter. On `step`, `idx` increments and wraps 3→0.
- **Snapshot on wrap** (the step where `idx` goes 3→0):
  - `shadow_dig` takes `digits_in`; `shadow_dp` takes `dp_in`.
  - `frame_done` = 1 for that one cycle.
- **Blank counter:** on `step`, `blank_cnt` loads `DEAD_CYCLES`. Otherwise it decrements while nonzero.
- **Decode:** nibbles 0–9 use the standard patterns (e.g. 0 → `SEG`=1000000, 8 → 0000000). Nibbles 10–15 show a dash (g only, `SEG`=0111111) as an error marker.
- **Leading-zero blank** (`LZ_BLANK`=1): digit i (i = 3..1) is blank (`SEG`=1111111) when it and every higher digit in the snapshot are 0.
  - Digit 0 is never blanked.
  - `DP` still follows `shadow_dp` on a blanked digit.
- **Output selection:**
  - `AN` = 1111 when `enable`=0 or `blank_cnt`≠0.
  - Otherwise `AN` drives `idx` low only, e.g. `idx`=2 → `AN`=1011.
  - `SEG`/`DP` show the `idx` digit while its anode is driven, and 1111111/1 while all anodes are off.
- **`enable`=0:** `idx`, the snapshot and `blank_cnt` hold; steps are ignored. Scanning resumes on the next rising `NFrec` edge after `enable` returns to 1.
- **Step during dead time:** `blank_cnt` reloads and `idx` advances normally.

## Timing
- **Reset values:**
  - `idx`=0, `shadow_dig`=0, `shadow_dp`=0, `blank_cnt`=0, `nfrec_q`=1 (no spurious step if `NFrec` is high at release).
  - `AN`=1111, `SEG`=1111111, `DP`=1, `frame_done`=0.
- **Registered outputs:** `AN`, `SEG` and `DP` are registered from the state after the current edge.
- **Step at edge E:**
  - `idx` and `blank_cnt` update at E.
  - `AN` is 1111 at E+1 … E+`DEAD_CYCLES`.
  - The new digit appears at E+`DEAD_CYCLES`+1.
  - With `DEAD_CYCLES`=0, the new digit appears at E+1.
- **Edge detect latency:** an `NFrec` rising transition at edge N is seen as `step` at edge N+1.
- **`frame_done`:** registered; asserted during the cycle after the wrap step edge; width exactly 1 cycle.
- **Snapshot latency:** a change on `digits_in` becomes visible only after the next 3→0 wrap. Worst case is one full frame (4 steps).
- **Period constraint:** the `NFrec` period must be ≥ 2·(`DEAD_CYCLES`+2) cycles. Faster input is legal but produces reduced or zero lit time.
- **Mid-operation reset:** takes effect at the next edge; all state returns to reset values, and the display is dark in the following cycle.

## Test plan
- **Reset and first digit:** reset 3 cycles, then release with `NFrec`=1 held → no step, `AN`=1111. Next, `AN`=1110, `SEG`=1000000 (digit 0 shows "0"); digits 3..1 blank under `LZ_BLANK`=1.
- **Scan order and dead time:** `digits_in`=16'h1234, `DEAD_CYCLES`=2, `NFrec` toggling every 8 cycles.
  - After the first wrap, `AN` steps 1110→1101→1011→0111 with 2 cycles of 1111 between digits.
  - Digit 1 shows `SEG`=0110000 (3); digit 3 shows `SEG`=1111001 (1).
  - `frame_done` pulses once per 4 steps.
- **Leading zeros, decimal point and invalid nibble:** `digits_in`=16'h0050, `dp_in`=4'b0100 → digit 3 blank, digit 2 blank with `DP`=0, digit 1 shows 5, digit 0 shows 0. Then `digits_in`=16'h00A0 → digit 1 shows a dash (0111111).
- **Snapshot coherence:** change `digits_in` from 16'h1111 to 16'h2222 while `idx`=2 → digits 2 and 3 still show 1; all digits show 2 only after `frame_done`.
- **Enable freeze:** drop `enable` at `idx`=1 for 40 cycles → `AN`=1111 throughout and `idx` stays 1. After re-enable, the first step moves to `idx`=2.
- **Reset mid-dead-time:** assert `Reset` at E+1 after a step → `AN`=1111, `idx`=0 and `frame_done`=0 on the next cycle; the scan restarts cleanly.
